tbb_host_if: RTL and testbench
==============================

# tbb_host_if

Parametrised host-bus front end for the TBB sound core. It synchronises the pin-level nibble bus (D, A0, WR) into the core clock domain and assembles nibble writes into a bank of NUM_REGS registers of REG_W bits. It also generates the reset-release READY flag and the prescaled FCLK_EN tick consumed by the sound core. It sits between the padframe shell and the core, and replaces the fixed 5-stage reset shifter with a configurable prescaler and an addressed, auto-incrementing register file.

## Interface
Parameters:
- DATA_W, 4, host data bus width in bits.
- REG_W, 8, width of each register. Must be a multiple of DATA_W.
- NUM_REGS, 4, register count. ADDR_W = clog2(NUM_REGS), and ADDR_W ≤ DATA_W.
- DIV, 5, FCLK_EN period in clocks. DIV ≥ 1.
- RST_STAGES, 5, number of clocks from reset release to READY.
- AUTO_INC, 1, when 1 the address increments after each commit.

Ports:
- CLK  in  1  core clock.
- RST  in  1  reset, **asynchronous, active-high**.
- D  in  DATA_W  host data pins (asynchronous to CLK).
- A0  in  1  host select: 1 = address write, 0 = data write.
- WR  in  1  host write strobe; the rising edge is the event.
- REGS_O  out  NUM_REGS*REG_W  flattened register bank; register i occupies bits [i*REG_W +: REG_W].
- COMMIT  out  1  one-cycle pulse when a register is written.
- COMMIT_IDX  out  ADDR_W  index of the last committed register.
- FCLK_EN  out  1  prescaler tick.
- READY  out  1  high once the reset-release sequence completes.

## Operation
- Reset values: REGS_O=0, COMMIT=0, COMMIT_IDX=0, FCLK_EN=0, READY=0. The internal address, nibble counter, prescaler and synchroniser flops are all 0.
- D, A0 and WR pass through identical 2-flop synchronisers. A third WR flop provides edge detection. A write event is sync2(WR)=1 with prev=0, and it uses the synchronised D/A0 from the same cycle.
- Events are ignored while READY=0.
- Address write (A0=1):
  - addr ← D[ADDR_W-1:0].
  - The nibble counter and the assembly register are cleared.
  - If D ≥ NUM_REGS, the address is flagged invalid.
- Data write (A0=0):
  - The nibble is placed at assembly[cnt*DATA_W +: DATA_W], least-significant nibble first, and cnt increments.
  - On the (REG_W/DATA_W)-th nibble, the full word is committed to REGS_O[addr], COMMIT pulses, COMMIT_IDX ← addr, and cnt ← 0.
  - If AUTO_INC=1, addr ← (addr+1) mod NUM_REGS (wraps).
  - If the address is invalid, the commit is dropped: no COMMIT pulse and no register change. cnt still resets.
- READY: a RST_STAGES-long shift register is filled with 1s and asynchronously cleared by RST. READY is its last stage.
- Prescaler: counts 0..DIV-1 only while READY=1. FCLK_EN=1 while the count equals DIV-1. With DIV=1, FCLK_EN stays high whenever READY=1.
- RST asserted mid-operation immediately clears all state, including any partial word and pending edge. No commit occurs.

## Timing
- READY rises on the RST_STAGES-th rising CLK edge after RST deasserts.
- First FCLK_EN high cycle: DIV cycles after READY rises. After that, the period is exactly DIV cycles.
- Pin WR rise to action is 3 CLK edges: sync1, sync2, then the action edge. On the action edge, REGS_O, COMMIT and COMMIT_IDX update together.
- COMMIT is high for exactly one cycle.
- Host timing requirements:
  - WR high ≥ 2 CLK periods and low ≥ 2 CLK periods.
  - D/A0 stable from 2 CLKs before the WR rise until 3 CLKs after it.
  - Violations are undefined behaviour, not error-checked.
- WR held high produces a single event. No repeats.

## Structure
- Package tbb_pkg holds:
  - the clog2 function;
  - default constants TBB_DATA_W=4, TBB_REG_W=8, TBB_NUM_REGS=4;
  - A0 encodings TBB_SEL_DATA=0 and TBB_SEL_ADDR=1.
- Sub-module tbb_sync: parametrised-width 2-flop synchroniser with asynchronous active-high reset. It is instantiated for {WR, A0, D}.
- The top holds the edge detect, assembly and write FSM (IDLE/ASSEMBLE implied by cnt), register bank, READY shifter and prescaler.

## Test plan
All scenarios use defaults (DATA_W=4, REG_W=8, NUM_REGS=4, DIV=5) unless noted.
- Reset release: deassert RST → READY=1 on edge 5. FCLK_EN first high 5 cycles later, then every 5 cycles. A WR event before READY leaves REGS_O=0.
- Addressed write: A0=1 D=2, then A0=0 D=0xA, then D=0x5 → REGS_O[2]=0x5A, COMMIT single pulse 3 edges after the second WR rise, COMMIT_IDX=2.
- Auto-increment wrap: address 3, write 4 nibbles 1,2,3,4 → REGS_O[3]=0x21, REGS_O[0]=0x43, two COMMIT pulses, addr back to 1.
- Invalid address: NUM_REGS=3, address 3, write 2 nibbles → no COMMIT, REGS_O unchanged. Then address 0 and write 2 nibbles → commits normally.
- Partial word abort: one data nibble, then an address write to 1, then 2 nibbles 0xC,0x3 → REGS_O[1]=0x3C (stale nibble discarded). RST between the two nibbles of a word clears everything, with no COMMIT.
- DIV=1 and a WR held high for 20 cycles → FCLK_EN constantly high after READY. Exactly one event is recorded.

Source files
------------

// File: rtl/tbb_pkg.sv
// Shared constants, host-select encoding and width helper for the TBB host-bus front end.
// Pure definitions: no latency, no backpressure.
package tbb_pkg;
    localparam int TBB_DATA_W   = 4;
    localparam int TBB_REG_W    = 8;
    localparam int TBB_NUM_REGS = 4;

    typedef enum logic {
        TBB_SEL_DATA = 1'b0,
        TBB_SEL_ADDR = 1'b1
    } tbb_sel_e;

    // Floor of 1 keeps derived vector widths legal for single-entry configurations.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r = r + 1;
        return (r < 1) ? 1 : r;
    endfunction
endpackage

// File: rtl/tbb_sync.sv
// W-bit two-flop synchroniser for quasi-static host pins; latency 2 CLK.
// No backpressure: samples every cycle, host guarantees pin stability.
module tbb_sync #(
    parameter int W = 1
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [W-1:0] s1;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            s1 <= '0;
            q  <= '0;
        end else begin
            s1 <= d;
            q  <= s1;
        end
    end
endmodule

// File: rtl/tbb_host_if.sv
// Host nibble bus -> addressed register bank, plus READY release and FCLK_EN prescaler.
// Pin WR rise to COMMIT/REGS_O update is 3 CLK edges; no backpressure, host paces writes.
module tbb_host_if
    import tbb_pkg::*;
#(
    parameter int DATA_W     = TBB_DATA_W,
    parameter int REG_W      = TBB_REG_W,
    parameter int NUM_REGS   = TBB_NUM_REGS,
    parameter int DIV        = 5,
    parameter int RST_STAGES = 5,
    parameter bit AUTO_INC   = 1'b1,
    localparam int ADDR_W    = clog2(NUM_REGS)
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [DATA_W-1:0]         D,
    input  logic                      A0,
    input  logic                      WR,
    output logic [NUM_REGS*REG_W-1:0] REGS_O,
    output logic                      COMMIT,
    output logic [ADDR_W-1:0]         COMMIT_IDX,
    output logic                      FCLK_EN,
    output logic                      READY
);
    localparam int NIBS   = REG_W / DATA_W;
    localparam int CNT_W  = clog2(NIBS);
    localparam int PCNT_W = clog2(DIV);

    logic [DATA_W+1:0]     sync_q;
    logic [DATA_W-1:0]     d_s;
    logic                  a0_s;
    logic                  wr_s;
    logic                  wr_prev;
    logic                  wr_evt;
    logic [ADDR_W-1:0]     addr;
    logic                  addr_ok;
    logic [CNT_W-1:0]      cnt;
    logic                  last_nib;
    logic [REG_W-1:0]      asm_q;
    logic [REG_W-1:0]      asm_nxt;
    logic [RST_STAGES-1:0] rdy_sr;
    logic [PCNT_W-1:0]     pcnt;

    tbb_sync #(.W(DATA_W + 2)) u_sync (
        .CLK (CLK),
        .RST (RST),
        .d   ({WR, A0, D}),
        .q   (sync_q)
    );

    assign wr_s     = sync_q[DATA_W+1];
    assign a0_s     = sync_q[DATA_W];
    assign d_s      = sync_q[DATA_W-1:0];
    assign wr_evt   = READY && wr_s && !wr_prev;
    assign last_nib = (cnt == CNT_W'(NIBS - 1));
    assign READY    = rdy_sr[RST_STAGES-1];

    always_comb begin
        asm_nxt = asm_q;
        asm_nxt[cnt*DATA_W +: DATA_W] = d_s;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_prev    <= 1'b0;
            addr       <= '0;
            addr_ok    <= 1'b1;
            cnt        <= '0;
            asm_q      <= '0;
            REGS_O     <= '0;
            COMMIT     <= 1'b0;
            COMMIT_IDX <= '0;
        end else begin
            wr_prev <= wr_s;
            COMMIT  <= 1'b0;
            if (wr_evt) begin
                if (tbb_sel_e'(a0_s) == TBB_SEL_ADDR) begin
                    addr    <= d_s[ADDR_W-1:0];
                    addr_ok <= (32'(d_s) < NUM_REGS);
                    cnt     <= '0;
                    asm_q   <= '0;
                end else if (!last_nib) begin
                    asm_q <= asm_nxt;
                    cnt   <= cnt + 1'b1;
                end else begin
                    cnt   <= '0;
                    asm_q <= '0;
                    // An out-of-range address stays poisoned until the next address write.
                    if (addr_ok) begin
                        REGS_O[addr*REG_W +: REG_W] <= asm_nxt;
                        COMMIT     <= 1'b1;
                        COMMIT_IDX <= addr;
                        if (AUTO_INC)
                            addr <= (addr == ADDR_W'(NUM_REGS - 1)) ? '0 : addr + 1'b1;
                    end
                end
            end
        end
    end

    // Prescaler only runs once READY is up; FCLK_EN is registered off the terminal count.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rdy_sr  <= '0;
            pcnt    <= '0;
            FCLK_EN <= 1'b0;
        end else begin
            rdy_sr  <= (rdy_sr << 1) | RST_STAGES'(1);
            FCLK_EN <= READY && (pcnt == PCNT_W'(DIV - 1));
            if (READY)
                pcnt <= (pcnt == PCNT_W'(DIV - 1)) ? '0 : pcnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_tbb_host_if.sv
// Bench for tbb_host_if: three configurations share one host bus, each checked every cycle
// against a register-level model of the host protocol, plus literal spot checks.
module tb_tbb_host_if;
    localparam int RS = 5;

    logic        CLK, RST, A0, WR;
    logic [3:0]  D;
    logic [2:0]  commit, fclk, ready;
    logic [1:0]  idx0, idx1, idx2;
    logic [31:0] regs0, regs2;
    logic [23:0] regs1;

    int tests = 0;
    int fails = 0;

    tbb_host_if #(.NUM_REGS(4), .DIV(5)) u0 (
        .CLK(CLK), .RST(RST), .D(D), .A0(A0), .WR(WR), .REGS_O(regs0),
        .COMMIT(commit[0]), .COMMIT_IDX(idx0), .FCLK_EN(fclk[0]), .READY(ready[0]));
    tbb_host_if #(.NUM_REGS(3), .DIV(5)) u1 (
        .CLK(CLK), .RST(RST), .D(D), .A0(A0), .WR(WR), .REGS_O(regs1),
        .COMMIT(commit[1]), .COMMIT_IDX(idx1), .FCLK_EN(fclk[1]), .READY(ready[1]));
    tbb_host_if #(.NUM_REGS(4), .DIV(1)) u2 (
        .CLK(CLK), .RST(RST), .D(D), .A0(A0), .WR(WR), .REGS_O(regs2),
        .COMMIT(commit[2]), .COMMIT_IDX(idx2), .FCLK_EN(fclk[2]), .READY(ready[2]));

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Model state: per instance register contents, pointer, validity, pending low nibble.
    int         nregs [3] = '{4, 3, 4};
    int         divs  [3] = '{5, 5, 1};
    logic [7:0] m_regs [3][4];
    int         m_addr [3];
    int         m_cnt  [3];
    int         m_idx  [3];
    bit         m_ok   [3];
    bit         m_commit [3];
    logic [3:0] m_lo   [3];
    int         rel = 0;
    int         cyc = 0;
    int         ccnt [3] = '{0, 0, 0};

    typedef struct {
        int         act;
        bit         a0;
        logic [3:0] d;
    } ev_t;
    ev_t evq[$];

    function automatic void model_reset();
        for (int i = 0; i < 3; i++) begin
            for (int r = 0; r < 4; r++) m_regs[i][r] = 8'h00;
            m_addr[i] = 0; m_cnt[i] = 0; m_idx[i] = 0;
            m_ok[i] = 1'b1; m_commit[i] = 1'b0; m_lo[i] = 4'h0;
        end
        rel = 0;
        evq.delete();
    endfunction

    function automatic void model_host_write(int i, bit a0, logic [3:0] d);
        if (a0) begin
            m_addr[i] = int'(d) % 4;
            m_ok[i]   = int'(d) < nregs[i];
            m_cnt[i]  = 0;
        end else if (m_cnt[i] == 0) begin
            m_lo[i]  = d;
            m_cnt[i] = 1;
        end else begin
            m_cnt[i] = 0;
            if (m_ok[i]) begin
                m_regs[i][m_addr[i]] = {d, m_lo[i]};
                m_commit[i] = 1'b1;
                m_idx[i]    = m_addr[i];
                m_addr[i]   = (m_addr[i] + 1) % nregs[i];
            end
        end
    endfunction

    function automatic logic [31:0] exp_flat(int i);
        logic [31:0] v = '0;
        for (int r = 0; r < nregs[i]; r++) v[r*8 +: 8] = m_regs[i][r];
        return v;
    endfunction

    function automatic bit exp_fclk(int i);
        return (rel >= RS + divs[i]) && ((rel - RS) % divs[i] == 0);
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Model advances just after each rising edge; host events act on their third edge.
    always @(posedge CLK) begin
        #1;
        cyc++;
        for (int i = 0; i < 3; i++) m_commit[i] = 1'b0;
        if (!RST) begin
            rel++;
            while (evq.size() > 0 && evq[0].act <= cyc) begin
                if (evq[0].act == cyc && rel - 1 >= RS)
                    for (int i = 0; i < 3; i++) model_host_write(i, evq[0].a0, evq[0].d);
                void'(evq.pop_front());
            end
        end
    end

    always @(negedge CLK) begin
        logic [31:0] ar [3];
        logic [1:0]  ai [3];
        ar[0] = regs0; ar[1] = {8'h00, regs1}; ar[2] = regs2;
        ai[0] = idx0;  ai[1] = idx1;           ai[2] = idx2;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("regs_u%0d", i),   ar[i], exp_flat(i));
            check($sformatf("commit_u%0d", i), {31'b0, commit[i]}, {31'b0, m_commit[i]});
            check($sformatf("idx_u%0d", i),    {30'b0, ai[i]}, 32'(m_idx[i]));
            check($sformatf("ready_u%0d", i),  {31'b0, ready[i]}, {31'b0, rel >= RS});
            check($sformatf("fclk_u%0d", i),   {31'b0, fclk[i]}, {31'b0, exp_fclk(i)});
            if (commit[i]) ccnt[i]++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #2;
    endtask

    task automatic host_write(input bit a0, input logic [3:0] d, input int hold);
        ev_t e;
        A0 = a0; D = d;
        tick(2);
        WR = 1'b1;
        e.act = cyc + 3; e.a0 = a0; e.d = d;
        evq.push_back(e);
        tick(hold);
        WR = 1'b0;
        tick(3);
    endtask

    initial begin
        int   c0;
        ev_t  e;
        RST = 1'b1; A0 = 1'b0; WR = 1'b0; D = 4'h0;
        model_reset();
        tick(2);
        check("lit_rst_ready", {31'b0, ready[0]}, 32'd0);
        check("lit_rst_regs",  regs0, 32'd0);
        check("lit_rst_fclk",  {31'b0, fclk[0]}, 32'd0);

        // Reset release: READY on edge 5, FCLK_EN (DIV=5) first on edge 10.
        RST = 1'b0;
        tick(4);
        check("lit_ready_e4", {31'b0, ready[0]}, 32'd0);
        tick(1);
        check("lit_ready_e5", {31'b0, ready[0]}, 32'd1);
        tick(4);
        check("lit_fclk_e9",  {31'b0, fclk[0]}, 32'd0);
        check("lit_fclk1_e9", {31'b0, fclk[2]}, 32'd1);
        tick(1);
        check("lit_fclk_e10", {31'b0, fclk[0]}, 32'd1);

        // Addressed write; second nibble done by hand to pin the 3-edge latency.
        host_write(1'b1, 4'h2, 3);
        host_write(1'b0, 4'hA, 3);
        A0 = 1'b0; D = 4'h5;
        tick(2);
        WR = 1'b1;
        e.act = cyc + 3; e.a0 = 1'b0; e.d = 4'h5;
        evq.push_back(e);
        tick(2);
        check("lit_commit_e2", {31'b0, commit[0]}, 32'd0);
        tick(1);
        check("lit_commit_e3", {31'b0, commit[0]}, 32'd1);
        tick(1);
        check("lit_commit_e4", {31'b0, commit[0]}, 32'd0);
        WR = 1'b0;
        tick(3);
        check("lit_reg2_5a", {24'b0, regs0[23:16]}, 32'h5A);
        check("lit_idx_2",   {30'b0, idx0}, 32'd2);
        check("lit_ccnt_1",  32'(ccnt[0]), 32'd1);

        // Auto-increment wrap 3 -> 0 -> 1; address 3 is out of range for u1.
        host_write(1'b1, 4'h3, 3);
        host_write(1'b0, 4'h1, 3);
        host_write(1'b0, 4'h2, 3);
        host_write(1'b0, 4'h3, 3);
        host_write(1'b0, 4'h4, 3);
        check("lit_reg3_21",   {24'b0, regs0[31:24]}, 32'h21);
        check("lit_reg0_43",   {24'b0, regs0[7:0]}, 32'h43);
        check("lit_ccnt_3",    32'(ccnt[0]), 32'd3);
        check("lit_u1_unchg",  {8'b0, regs1}, 32'h5A0000);
        check("lit_u1_ccnt_1", 32'(ccnt[1]), 32'd1);
        host_write(1'b0, 4'h8, 3);
        host_write(1'b0, 4'h9, 3);
        check("lit_reg1_98", {24'b0, regs0[15:8]}, 32'h98);
        host_write(1'b1, 4'h0, 3);
        host_write(1'b0, 4'h6, 3);
        host_write(1'b0, 4'h7, 3);
        check("lit_u1_reg0_76", {24'b0, regs1[7:0]}, 32'h76);
        check("lit_u1_ccnt_2",  32'(ccnt[1]), 32'd2);

        // Partial word abandoned by an address write.
        host_write(1'b0, 4'hE, 3);
        host_write(1'b1, 4'h1, 3);
        host_write(1'b0, 4'hC, 3);
        host_write(1'b0, 4'h3, 3);
        check("lit_reg1_3c",    {24'b0, regs0[15:8]}, 32'h3C);
        check("lit_u1_reg1_3c", {24'b0, regs1[15:8]}, 32'h3C);

        // Reset between the two nibbles of a word.
        host_write(1'b1, 4'h2, 3);
        host_write(1'b0, 4'hB, 3);
        c0 = ccnt[0];
        RST = 1'b1;
        model_reset();
        tick(1);
        check("lit_midrst_regs",  regs0, 32'd0);
        check("lit_midrst_ready", {31'b0, ready[0]}, 32'd0);
        tick(2);
        RST = 1'b0;

        // Write before READY is ignored; a long WR high is one event only.
        host_write(1'b0, 4'hF, 3);
        host_write(1'b0, 4'h1, 20);
        host_write(1'b0, 4'h2, 3);
        check("lit_reg0_21",    {24'b0, regs0[7:0]}, 32'h21);
        check("lit_u2_reg0_21", {24'b0, regs2[7:0]}, 32'h21);
        check("lit_ccnt_after", 32'(ccnt[0]), 32'(c0 + 1));
        check("lit_div1_fclk",  {31'b0, fclk[2]}, 32'd1);

        tick(2);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
